// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Posted-write buffer between the EX/MEM pipeline register and
//             data_memory. Stores are queued in a circular FIFO and retire
//             to memory when the port is free. Loads search the queue so the
//             youngest value for an address is always returned. Loads that
//             miss the queue go straight to data_memory.
//  Ports    : clock_in, reset_n       - clock, async active-low reset
//             memWrite/memRead/address/writeData - CPU MEM-stage request
//             readData, stall          - CPU load result / hold request
//             drain_en                 - memory port free for retiring
//             mem_*                    - data_memory interface
//             count, empty             - occupancy status
//  Config   : STORE_BUFFER_FWD_EN defined   -> load hits forward from buffer
//             STORE_BUFFER_FWD_EN undefined -> load hits stall until the
//                                              matching stores have drained
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   memWrite,
  input  logic                   memRead,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      writeData,
  output logic [DATA_W-1:0]      readData,
  output logic                   stall,
  input  logic                   drain_en,
  output logic                   mem_memWrite,
  output logic                   mem_memRead,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_writeData,
  input  logic [DATA_W-1:0]      mem_readData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  // Entry storage and queue state
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  logic               w_full;
  logic               w_empty;
  logic               w_store;
  logic               w_load;
  logic               w_hit;
  logic               w_load_miss;
  logic               w_enq;
  logic               w_deq;
  logic [c_PTR_W-1:0] w_idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [DATA_W-1:0]  w_hit_data;
`endif

  assign w_full  = (count_q == c_FULL_CNT);
  assign w_empty = (count_q == '0);

  // A simultaneous read+write request is treated as a plain store.
  assign w_store = memWrite;
  assign w_load  = memRead & ~memWrite;

  // Walk the queue oldest -> youngest; later matches overwrite earlier ones,
  // so the youngest matching entry is what remains at the end.
  always_comb begin : p_search
    w_hit = 1'b0;
    w_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    w_hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head_q + c_PTR_W'(i);
      if (valid_q[w_idx] && (addr_q[w_idx] == address)) begin
        w_hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        w_hit_data = data_q[w_idx];
`endif
      end
    end
  end

  assign w_load_miss = w_load & ~w_hit;
  assign w_enq       = w_store & ~w_full;
  // A load miss owns the memory port this cycle, so draining yields to it.
  assign w_deq       = drain_en & ~w_empty & ~w_load_miss;

  // Queue next-state
  always_comb begin : p_next
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    // Head and tail can only coincide when empty (no dequeue) or full
    // (no enqueue), so the two valid updates never collide.
    if (w_enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + c_PTR_W'(1);
    end
    if (w_deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + c_PTR_W'(1);
    end
    case ({w_enq, w_deq})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin : p_state
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clock_in) begin : p_store
    if (reset_n && w_enq) begin
      addr_q[tail_q] <= address;
      data_q[tail_q] <= writeData;
    end
  end

  // CPU and memory side outputs. Everything is forced to zero while reset
  // is asserted so the memory never sees a stray request.
  always_comb begin : p_out
    readData      = '0;
    stall         = 1'b0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    if (reset_n) begin
      if (w_store && w_full) begin
        stall = 1'b1;
      end
      if (w_load) begin
        if (w_hit) begin
`ifdef STORE_BUFFER_FWD_EN
          readData = w_hit_data;
`else
          // Hold the load until every matching store has reached memory.
          stall = 1'b1;
`endif
        end else begin
          mem_memRead = 1'b1;
          mem_address = address;
          readData    = mem_readData;
        end
      end
      if (w_deq) begin
        mem_memWrite  = 1'b1;
        mem_address   = addr_q[head_q];
        mem_writeData = data_q[head_q];
      end
    end
  end

  assign count = count_q;
  assign empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed self-checking bench for store_buffer with a simple
//             data_memory model and a log of retired stores.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  logic        clk;
  logic        reset_n;
  logic        memWrite;
  logic        memRead;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        drain_en;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  // data_memory model plus retire log
  logic [31:0] dmem   [0:255];
  logic [31:0] wlog_a [0:63];
  logic [31:0] wlog_d [0:63];
  int          wlog_n = 0;
  logic        ovr_en;
  logic [31:0] ovr_data;

  assign mem_readData = ovr_en ? ovr_data : dmem[8'(mem_address)];

  always @(posedge clk) begin
    if (mem_memWrite) begin
      dmem[8'(mem_address)]  <= mem_writeData;
      wlog_a[6'(wlog_n)]     <= mem_address;
      wlog_d[6'(wlog_n)]     <= mem_writeData;
      wlog_n                 <= wlog_n + 1;
    end
  end

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock_in      (clk),
    .reset_n       (reset_n),
    .memWrite      (memWrite),
    .memRead       (memRead),
    .address       (address),
    .writeData     (writeData),
    .readData      (readData),
    .stall         (stall),
    .drain_en      (drain_en),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_readData  (mem_readData),
    .count         (count),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic de);
    memWrite  = w;
    memRead   = r;
    address   = a;
    writeData = d;
    drain_en  = de;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while (!empty && k < 20) begin
      tick();
      k++;
    end
    chk(tag, {63'd0, empty}, 64'd1);
  endtask

  initial begin
    int base;
    ovr_en   = 1'b0;
    ovr_data = '0;
    reset_n  = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_rdata", 64'(readData), 64'd0);
    chk("rst_memwr", 64'(mem_memWrite), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ---- single store retires to memory ----
    drive(1'b1, 1'b0, 32'h0F, 32'd3, 1'b1);
    #1;
    chk("st1_no_drain_yet", 64'(mem_memWrite), 64'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("st1_memwr", 64'(mem_memWrite), 64'd1);
    chk("st1_addr", 64'(mem_address), 64'h0F);
    chk("st1_data", 64'(mem_writeData), 64'd3);
    tick();
    #1;
    chk("st1_empty", 64'(empty), 64'd1);
    chk("st1_dmem", 64'(dmem[8'h0F]), 64'd3);

    // ---- youngest-value load ----
    tick();
    drive(1'b1, 1'b0, 32'h0F, 32'd3, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0F, 32'd7, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0F, 32'h0, 1'b0);
    #1;
    chk("ld_count", 64'(count), 64'd2);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_rdata", 64'(readData), 64'd7);
    chk("fwd_memrd", 64'(mem_memRead), 64'd0);
    chk("fwd_stall", 64'(stall), 64'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    wait_empty("fwd_drain_empty");
    chk("fwd_dmem", 64'(dmem[8'h0F]), 64'd7);
`else
    chk("nf_stall", 64'(stall), 64'd1);
    chk("nf_memrd", 64'(mem_memRead), 64'd0);
    chk("nf_rdata", 64'(readData), 64'd0);
    tick();
    #1;
    chk("nf_stall_hold", 64'(stall), 64'd1);
    drive(1'b0, 1'b1, 32'h0F, 32'h0, 1'b1);
    #1;
    chk("nf_drain1_wr", 64'(mem_memWrite), 64'd1);
    chk("nf_drain1_data", 64'(mem_writeData), 64'd3);
    chk("nf_drain1_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("nf_drain2_data", 64'(mem_writeData), 64'd7);
    chk("nf_drain2_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("nf_done_stall", 64'(stall), 64'd0);
    chk("nf_done_memrd", 64'(mem_memRead), 64'd1);
    chk("nf_done_rdata", 64'(readData), 64'd7);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

    // ---- full queue, stall, wrap ----
    base = wlog_n;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h10 + 32'(i), 32'(i + 1), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h14, 32'd5, 1'b0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("full_count_hold", 64'(count), 64'd4);
    drive(1'b1, 1'b0, 32'h14, 32'd5, 1'b1);
    #1;
    chk("full_drain_stall", 64'(stall), 64'd1);
    chk("full_drain_addr", 64'(mem_address), 64'h10);
    tick();
    #1;
    chk("full_freed_count", 64'(count), 64'd3);
    chk("full_freed_stall", 64'(stall), 64'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("enq_deq_count", 64'(count), 64'd3);
    wait_empty("wrap_empty");
    for (int k = 0; k < 5; k++) begin
      chk("retire_addr", 64'(wlog_a[6'(base + k)]), 64'h10 + 64'(k));
      chk("retire_data", 64'(wlog_d[6'(base + k)]), 64'(k + 1));
    end

    // ---- load miss has priority over drain ----
    drive(1'b1, 1'b0, 32'h30, 32'h11, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h31, 32'h22, 1'b0);
    tick();
    ovr_en   = 1'b1;
    ovr_data = 32'hAB;
    drive(1'b0, 1'b1, 32'h20, 32'h0, 1'b1);
    #1;
    chk("miss_rdata", 64'(readData), 64'hAB);
    chk("miss_memrd", 64'(mem_memRead), 64'd1);
    chk("miss_no_drain", 64'(mem_memWrite), 64'd0);
    chk("miss_addr", 64'(mem_address), 64'h20);
    tick();
    ovr_en = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("miss_count", 64'(count), 64'd2);
    chk("resume_memwr", 64'(mem_memWrite), 64'd1);
    chk("resume_addr", 64'(mem_address), 64'h30);
    wait_empty("miss_empty");

    // ---- illegal read+write: store only ----
    drive(1'b1, 1'b1, 32'h05, 32'd9, 1'b0);
    #1;
    chk("both_rdata", 64'(readData), 64'd0);
    chk("both_memrd", 64'(mem_memRead), 64'd0);
    tick();
    drive(1'b0, 1'b1, 32'h05, 32'h0, 1'b0);
    #1;
    chk("both_count", 64'(count), 64'd1);
`ifdef STORE_BUFFER_FWD_EN
    chk("both_fwd", 64'(readData), 64'd9);
`else
    chk("both_nf_stall", 64'(stall), 64'd1);
`endif
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    wait_empty("both_empty");
    chk("both_dmem", 64'(dmem[8'h05]), 64'd9);

    // ---- async reset mid-operation ----
    drive(1'b1, 1'b0, 32'h40, 32'd1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h41, 32'd2, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("pre_rst_count", 64'(count), 64'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_memwr", 64'(mem_memWrite), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("post_rst_memwr", 64'(mem_memWrite), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the EX/MEM pipeline register and data_memory.
- Stores are queued in a small FIFO and retire to data_memory when its port is free, so a store costs no memory-port cycle in the MEM stage.
- Loads search the queue so a load always returns the youngest value for its address; a load that misses the queue goes straight to data_memory.

Parameters:
- DEPTH, 4, number of queued stores; power of two, ≥2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock_in  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- memWrite  in  1  CPU store request (MEM stage).
- memRead  in  1  CPU load request (MEM stage).
- address  in  ADDR_W  CPU word address.
- writeData  in  DATA_W  CPU store data.
- readData  out  DATA_W  load result, combinational, same cycle.
- stall  out  1  hold MEM stage; request not accepted this cycle.
- drain_en  in  1  memory port available for retiring stores.
- mem_memWrite  out  1  to data_memory memWrite.
- mem_memRead  out  1  to data_memory memRead.
- mem_address  out  ADDR_W  to data_memory address.
- mem_writeData  out  DATA_W  to data_memory writeData.
- mem_readData  in  DATA_W  from data_memory readData; combinational.
- count  out  $clog2(DEPTH)+1  entries held.
- empty  out  1  count==0.

Behaviour:
- Reset (reset_n=0, async):
  - Head/tail pointers and count cleared; entries invalidated.
  - Outputs forced to: count=0, empty=1, stall=0, readData=0, all mem_* = 0.
  - Reset mid-operation discards all queued stores, which are lost.
- FIFO: circular, head/tail wrap modulo DEPTH; full = (count==DEPTH).
- Enqueue:
  - Condition: memWrite=1 and not full → {address, writeData} written at tail on the edge.
  - Latency: entry is eligible to drain from the next cycle.
- Store when full: stall=1 (combinational); nothing enqueued; CPU holds the request.
  - A drain in that cycle frees a slot; the store is accepted on the following cycle.
- Load address match: full-address equality against all valid entries; if several match, the youngest (closest to tail) wins.
- Load hit: readData = matching entry data; mem_memRead=0; stall=0.
- Load miss: mem_memRead=1, mem_address=address, readData=mem_readData; stall=0.
- Drain:
  - Condition: drain_en=1, not empty, and memory port not used by a load miss.
  - Memory-side drive: mem_memWrite=1, mem_address=head addr, mem_writeData=head data.
  - Head advances on the edge.
  - Drain is allowed in a load-hit cycle and in a store cycle.
- Priority: load miss > drain.
- Same-cycle enqueue + dequeue: count unchanged; pointers both advance.
- memWrite=1 and memRead=1 together (illegal): treated as store only; readData=0; mem_memRead=0.
- Idle (no request, no drain): mem_* = 0, readData=0.
- mem_address/mem_writeData are 0 whenever neither mem_memWrite nor mem_memRead is asserted.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: load hit forwards from the buffer as above.
- Undefined:
  - No forwarding. A load matching any valid entry asserts stall=1 with mem_memRead=0 and readData=0.
  - Drain continues, subject to drain_en, until no matching entry remains.
  - The load is then serviced from data_memory.
- Load misses behave identically in both builds.

Test Plan:
- Reset: reset_n=0 while count=2 → count=0, empty=1, stall=0, mem_memWrite=0 immediately (async), before the next clock edge.
- Store address=0x0F, writeData=3, drain_en=1 → next cycle mem_memWrite=1, mem_address=0x0F, mem_writeData=3; following cycle empty=1; data_memory[0x0F]=3.
- drain_en=0; store 0x0F=3, then 0x0F=7; load 0x0F:
  - FWD_EN build → readData=7, mem_memRead=0.
  - Non-FWD build → stall=1 until drain_en=1 retires both entries, then readData=7 from memory.
- drain_en=0; 4 stores to 0x10..0x13 (data 1..4):
  - count=4; 5th store 0x14 → stall=1, count stays 4.
  - drain_en=1 → 0x10 retires, 5th store accepted next cycle.
  - Retire order 0x10,0x11,0x12,0x13,0x14 (pointer wrap exercised).
- count=2, drain_en=1; load miss 0x20 with mem_readData=0xAB → readData=0xAB, mem_memRead=1, no drain that cycle, count=2; next idle cycle drain resumes.
- Store 0x05=9 and memRead=1 same cycle → entry enqueued, readData=0, mem_memRead=0.
